// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller scheduler: FSM state encoding,
// SDRAM command words {cs_n,ras_n,cas_n,we_n} and the default refresh interval.
// No logic; imported by sdram_arbiter and sdram_ref_timer.
package sdram_pkg;

    // Scheduler states; the numeric values are fixed so the encoding can be
    // read directly off a waveform.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    // clk_ref cycles between auto-refresh requests (7.5 us at 100 MHz).
    localparam int unsigned REF_CYCLES_DEF = 750;

endpackage : sdram_pkg

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh request generator with sticky overrun detection.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i counts enable (init done);
//        ack_i refresh-start acknowledge; aref_req_o pending refresh; ref_overrun_o sticky error.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int unsigned REF_CYCLES = REF_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic ack_i,
    output logic aref_req_o,
    output logic ref_overrun_o
);

    localparam int unsigned CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aref_req_q, aref_req_d;
    logic             overrun_q, overrun_d;
    logic             wrap;

    // Counter only advances once the device is initialised; it freezes
    // (does not clear) if the enable ever drops.
    assign wrap = en_i && (cnt_q == CNT_W'(REF_CYCLES - 1));

    always_comb begin
        cnt_d      = cnt_q;
        aref_req_d = aref_req_q;
        overrun_d  = overrun_q;
        if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        // A fresh request outranks the acknowledge of the previous one, so a
        // wrap coinciding with the ack leaves exactly one request pending.
        if (wrap) begin
            aref_req_d = 1'b1;
        end else if (ack_i) begin
            aref_req_d = 1'b0;
        end
        // An interval elapsed with the previous refresh still unserved.
        if (wrap && aref_req_q && !ack_i) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            aref_req_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            aref_req_q <= aref_req_d;
            overrun_q  <= overrun_d;
        end
    end

    assign aref_req_o    = aref_req_q;
    assign ref_overrun_o = overrun_q;

endmodule : sdram_ref_timer

// File: rtl/sdram_arbiter.sv
// Central SDRAM scheduler: arbitrates init/refresh/write/read engines and muxes the active bus.
// Ports: clk_ref/rst_n; per-engine *_cmd/_ba/_addr buses and *_end done strobes; wr_req/rd_req
//        levels in; aref_en/wr_en/rd_en start pulses, muxed sdram_* pins and ref_overrun out.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned REF_CYCLES = REF_CYCLES_DEF,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned BA_W       = 2
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_dq_oe,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_dq_oe,
    output logic              ref_overrun
);

    arb_state_t state_q, state_d;
    logic       aref_en_q, aref_en_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       aref_req;

    // The registered aref_en is the acknowledge: the pending request clears
    // at the end of the first AREF cycle.
    sdram_ref_timer #(
        .REF_CYCLES (REF_CYCLES)
    ) u_ref_timer (
        .clk_i         (clk_ref),
        .rst_ni        (rst_n),
        .en_i          (init_end),
        .ack_i         (aref_en_q),
        .aref_req_o    (aref_req),
        .ref_overrun_o (ref_overrun)
    );

    // Next state and start pulses. Nothing moves while init_end is low, which
    // also covers the unexpected case of init_end dropping after init.
    always_comb begin
        state_d   = state_q;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        if (init_end) begin
            case (state_q)
                ST_INIT: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (aref_req) begin
                        state_d   = ST_AREF;
                        aref_en_d = 1'b1;
                    end else if (wr_req) begin
                        state_d = ST_WRITE;
                        wr_en_d = 1'b1;
                    end else if (rd_req) begin
                        state_d = ST_READ;
                        rd_en_d = 1'b1;
                    end
                end
                // Bursts run to completion; only the matching end strobe counts.
                ST_AREF:  if (aref_end) state_d = ST_IDLE;
                ST_WRITE: if (wr_end)   state_d = ST_IDLE;
                ST_READ:  if (rd_end)   state_d = ST_IDLE;
                default:  state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign aref_en = aref_en_q;
    assign wr_en   = wr_en_q;
    assign rd_en   = rd_en_q;

    // Pin mux off the registered state; IDLE and any illegal state drive NOP.
    always_comb begin
        sdram_cmd   = CMD_NOP;
        sdram_ba    = '0;
        sdram_addr  = '0;
        sdram_dq_oe = 1'b0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd   = wr_cmd;
                sdram_ba    = wr_ba;
                sdram_addr  = wr_addr;
                sdram_dq_oe = wr_dq_oe;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule : sdram_arbiter

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a mode-level model is compared on every falling edge,
// plus literal latency/flag expectations at the key points of each directed scenario.
// Inputs change 2 time units after the rising edge; outputs are sampled well away from it.
module tb_sdram_arbiter;

    localparam int REF    = 750;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;

    logic              clk_ref = 1'b0;
    logic              rst_n;
    logic              init_end, aref_end, wr_req, wr_end, rd_req, rd_end, wr_dq_oe;
    logic [3:0]        init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [BA_W-1:0]   init_ba, aref_ba, wr_ba, rd_ba;
    logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic              aref_en, wr_en, rd_en, sdram_dq_oe, ref_overrun;
    logic [3:0]        sdram_cmd;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 0;

    always #5 clk_ref = ~clk_ref;

    sdram_arbiter #(.REF_CYCLES(REF), .ADDR_W(ADDR_W), .BA_W(BA_W)) dut (
        .clk_ref(clk_ref), .rst_n(rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_dq_oe(wr_dq_oe),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_oe(sdram_dq_oe), .ref_overrun(ref_overrun)
    );

    // ---------------- behavioural model ----------------
    typedef enum int {M_INIT, M_IDLE, M_REF, M_WR, M_RD} mode_e;
    mode_e m_mode, m_next;
    int    m_ticks;      // enabled cycles since reset; a refresh falls due every REF of them
    bit    m_due, m_ovr, m_aref_en, m_wr_en, m_rd_en, m_wrap;

    always @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_INIT; m_ticks = 0; m_due = 0; m_ovr = 0;
            m_aref_en = 0; m_wr_en = 0; m_rd_en = 0;
        end else begin
            m_wrap = 0;
            m_next = m_mode;
            if (init_end) begin
                m_ticks++;
                m_wrap = (m_ticks % REF) == 0;
                case (m_mode)
                    M_INIT: m_next = M_IDLE;
                    M_IDLE: m_next = m_due ? M_REF : wr_req ? M_WR : rd_req ? M_RD : M_IDLE;
                    M_REF:  if (aref_end) m_next = M_IDLE;
                    M_WR:   if (wr_end)   m_next = M_IDLE;
                    M_RD:   if (rd_end)   m_next = M_IDLE;
                    default: m_next = M_INIT;
                endcase
            end
            if (m_wrap && m_due && !m_aref_en) m_ovr = 1;
            if (m_wrap) m_due = 1;
            else if (m_aref_en) m_due = 0;
            m_aref_en = (m_mode == M_IDLE) && (m_next == M_REF);
            m_wr_en   = (m_mode == M_IDLE) && (m_next == M_WR);
            m_rd_en   = (m_mode == M_IDLE) && (m_next == M_RD);
            m_mode    = m_next;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle compare of every output against the model.
    logic [23:0] exp_v, act_v;
    always @(negedge clk_ref) begin
        if (started) begin
            case (m_mode)
                M_INIT:  exp_v = {init_cmd, init_ba, init_addr, 1'b0, 4'b0};
                M_REF:   exp_v = {aref_cmd, aref_ba, aref_addr, 1'b0, 4'b0};
                M_WR:    exp_v = {wr_cmd, wr_ba, wr_addr, wr_dq_oe, 4'b0};
                M_RD:    exp_v = {rd_cmd, rd_ba, rd_addr, 1'b0, 4'b0};
                default: exp_v = {4'b0111, 2'b0, 13'b0, 1'b0, 4'b0};
            endcase
            exp_v[3:0] = {m_aref_en, m_wr_en, m_rd_en, m_ovr};
            act_v = {sdram_cmd, sdram_ba, sdram_addr, sdram_dq_oe,
                     aref_en, wr_en, rd_en, ref_overrun};
            chk("cycle_outputs", {8'b0, act_v}, {8'b0, exp_v});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_ref);
        #2;
        wr_dq_oe  = ~wr_dq_oe;
        init_addr = 13'($urandom);
        aref_addr = 13'($urandom);
        wr_addr   = 13'($urandom);
        rd_addr   = 13'($urandom);
    endtask

    function automatic logic en_of(input int sel);
        case (sel)
            0:       return aref_en;
            1:       return wr_en;
            default: return rd_en;
        endcase
    endfunction

    // Advance until the selected start pulse is seen; k = edges taken.
    task automatic wait_en(input int sel, input int bound, output int k);
        k = 0;
        forever begin
            step();
            k++;
            if (en_of(sel)) break;
            if (k >= bound) begin
                n_chk++;
                $display("FAIL wait_en_timeout: sel %0d not seen within %0d cycles", sel, bound);
                break;
            end
        end
    endtask

    task automatic pulse(input int sel);
        case (sel)
            0: aref_end = 1;
            1: wr_end   = 1;
            default: rd_end = 1;
        endcase
        step();
        aref_end = 0; wr_end = 0; rd_end = 0;
    endtask

    int k;

    initial begin
        rst_n = 0; init_end = 0; wr_req = 0; rd_req = 0;
        aref_end = 0; wr_end = 0; rd_end = 0; wr_dq_oe = 0;
        init_cmd = 4'b0010; init_ba = 2'd1; aref_cmd = 4'b0001; aref_ba = 2'd2;
        wr_cmd   = 4'b0100; wr_ba   = 2'd3; rd_cmd   = 4'b0101; rd_ba   = 2'd0;
        init_addr = 13'h0AA; aref_addr = 13'h155; wr_addr = 13'h1234; rd_addr = 13'h0F0F;
        repeat (3) step();
        started = 1;
        chk("reset_cmd_is_init", {28'b0, sdram_cmd}, 32'h2);
        chk("reset_flags_zero", {28'b0, aref_en, wr_en, rd_en, ref_overrun}, 32'h0);
        rst_n = 1;
        repeat (16) step();

        // Init done, no requests: IDLE NOP, first refresh 750 cycles later.
        init_end = 1;
        step();
        chk("idle_nop", {28'b0, sdram_cmd}, 32'h7);
        chk("idle_dq_oe", {31'b0, sdram_dq_oe}, 32'h0);
        wait_en(0, 900, k);
        chk("first_refresh_latency", k, 750);
        repeat (3) step();
        pulse(0);

        // wr and rd together: write wins, and keeps winning while held.
        wr_req = 1; rd_req = 1;
        wait_en(1, 10, k);
        chk("wr_before_rd", k, 1);
        repeat (5) step();
        pulse(1);
        chk("idle_gap_after_wr", {28'b0, sdram_cmd}, 32'h7);
        wait_en(1, 10, k);
        chk("wr_rearb_priority", k, 1);
        wr_req = 0;
        repeat (3) step();
        pulse(1);
        wait_en(2, 10, k);
        chk("rd_after_wr_drop", k, 1);
        rd_req = 0;
        repeat (4) step();
        pulse(2);

        // Refresh falls due mid-write: waits for wr_end, then beats rd_req.
        wr_req = 1;
        wait_en(1, 10, k);
        wr_req = 0; rd_req = 1;
        k = 0;
        while (!m_due && k < 800) begin step(); k++; end
        chk("refresh_due_seen", {31'b0, m_due}, 32'h1);
        repeat (40) step();
        chk("no_aref_mid_write", {31'b0, aref_en}, 32'h0);
        pulse(1);
        wait_en(0, 10, k);
        chk("aref_after_wr_end", k, 1);
        repeat (2) step();
        pulse(0);
        wait_en(2, 10, k);
        chk("rd_after_aref", k, 1);
        rd_req = 0;
        repeat (3) step();
        pulse(2);

        // Write held across two wraps: overrun sets and sticks.
        chk("overrun_clear_before", {31'b0, ref_overrun}, 32'h0);
        wr_req = 1;
        wait_en(1, 10, k);
        wr_req = 0;
        repeat (2 * REF + 50) step();
        chk("overrun_set", {31'b0, ref_overrun}, 32'h1);
        pulse(1);
        wait_en(0, 10, k);
        chk("aref_after_long_write", k, 1);
        repeat (2) step();
        pulse(0);
        step();
        chk("overrun_sticky", {31'b0, ref_overrun}, 32'h1);

        // Spurious rd_end during AREF is ignored.
        wait_en(0, 900, k);
        step();
        pulse(2);
        chk("aref_holds_on_rd_end", {28'b0, sdram_cmd}, 32'h1);
        chk("aref_dq_oe_low", {31'b0, sdram_dq_oe}, 32'h0);
        pulse(0);

        // Async reset in the middle of a read.
        rd_req = 1;
        wait_en(2, 10, k);
        chk("rd_start", k, 1);
        rd_req = 0;
        repeat (5) step();
        #1 rst_n = 0;
        #1;
        chk("midread_reset_cmd", {28'b0, sdram_cmd}, 32'h2);
        chk("midread_reset_flags", {28'b0, aref_en, wr_en, rd_en, ref_overrun}, 32'h0);
        step();
        rst_n = 1;
        step();
        wait_en(0, 900, k);
        chk("refresh_latency_after_reset", k, 750);
        repeat (2) step();
        pulse(0);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_sdram_arbiter
